// File: rtl/execute_stage_mc.sv
// EX pipeline stage: operand forwarding, single-cycle ALU and a shift-add multiplier
// that stalls the front end while it iterates. Owns the EX/MEM register.
module execute_stage_mc #(
  parameter int          DATA_W  = 32,
  parameter int          RADDR_W = 5,
  parameter logic [3:0]  CMD_MUL = 4'b1111
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               flush,
  input  logic [3:0]         ctr_ex,
  input  logic [2:0]         ctr_m,
  input  logic [1:0]         ctr_wb,
  input  logic [DATA_W-1:0]  reg1_data,
  input  logic [DATA_W-1:0]  reg2_data,
  input  logic [DATA_W-1:0]  immediate,
  input  logic [RADDR_W-1:0] rs,
  input  logic [RADDR_W-1:0] rt,
  input  logic [RADDR_W-1:0] rd,
  input  logic [3:0]         alu_cmd,
  input  logic [RADDR_W-1:0] ex_write_reg,
  input  logic               ex_regwrite_flag,
  input  logic [RADDR_W-1:0] mem_write_reg,
  input  logic               mem_regwrite_flag,
  input  logic [DATA_W-1:0]  ex_mem_data,
  input  logic [DATA_W-1:0]  mem_wb_data,
  output logic               stall_req,
  output logic [DATA_W-1:0]  reg_alu_out,
  output logic [DATA_W-1:0]  reg_reg2_data,
  output logic [RADDR_W-1:0] reg_write_reg,
  output logic [2:0]         reg_ctr_m,
  output logic [1:0]         reg_ctr_wb,
  output logic               reg_valid
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [3:0] CMD_AND = 4'd0;
  localparam logic [3:0] CMD_OR  = 4'd1;
  localparam logic [3:0] CMD_ADD = 4'd2;
  localparam logic [3:0] CMD_SUB = 4'd6;
  localparam logic [3:0] CMD_SLT = 4'd7;
  localparam logic [3:0] CMD_NOR = 4'd12;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {FWD_RF, FWD_EX, FWD_MEM} fwd_sel_t;

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic [DATA_W-1:0]    mul_acc;
  logic [DATA_W-1:0]    mul_mcand;
  logic [DATA_W-1:0]    mul_mplier;
  logic [DATA_W-1:0]    mul_b_q;
  logic [RADDR_W-1:0]   mul_dest_q;
  logic [2:0]           mul_ctr_m_q;
  logic [1:0]           mul_ctr_wb_q;

  fwd_sel_t             sel_a;
  fwd_sel_t             sel_b;
  logic [DATA_W-1:0]    op_a;
  logic [DATA_W-1:0]    fwd_b;
  logic [DATA_W-1:0]    op_b;
  logic [DATA_W-1:0]    alu_result;
  logic [DATA_W-1:0]    mul_step_acc;
  logic [RADDR_W-1:0]   dest;
  logic                 is_mul;
  logic                 accept_mul;

  // EX/MEM has priority over MEM/WB because it carries the younger result.
  function automatic fwd_sel_t fwd_select(input logic [RADDR_W-1:0] src);
    if (ex_regwrite_flag && (ex_write_reg != '0) && (ex_write_reg == src))
      return FWD_EX;
    else if (mem_regwrite_flag && (mem_write_reg != '0) && (mem_write_reg == src))
      return FWD_MEM;
    else
      return FWD_RF;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    op_a  = reg1_data;
    fwd_b = reg2_data;
    sel_a = fwd_select(rs);
    sel_b = fwd_select(rt);
    case (sel_a)
      FWD_EX:  op_a = ex_mem_data;
      FWD_MEM: op_a = mem_wb_data;
      default: op_a = reg1_data;
    endcase
    case (sel_b)
      FWD_EX:  fwd_b = ex_mem_data;
      FWD_MEM: fwd_b = mem_wb_data;
      default: fwd_b = reg2_data;
    endcase
    op_b = ctr_ex[0] ? immediate : fwd_b;
    dest = ctr_ex[3] ? rd : rt;
  end

  always_comb begin
    alu_result = '0;
    case (alu_cmd)
      CMD_AND: alu_result = op_a & op_b;
      CMD_OR:  alu_result = op_a | op_b;
      CMD_ADD: alu_result = op_a + op_b;
      CMD_SUB: alu_result = op_a - op_b;
      CMD_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      CMD_NOR: alu_result = ~(op_a | op_b);
      default: alu_result = '0;
    endcase
  end

  assign is_mul       = (alu_cmd == CMD_MUL);
  assign accept_mul   = (state == IDLE) && in_valid && is_mul && !flush;
  assign mul_step_acc = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;

  // Reset is gated in so the hazard unit never sees a stall while the stage is held in reset.
  assign stall_req = !rst && !flush &&
                     (accept_mul || ((state == BUSY) && (count != '0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      mul_acc       <= '0;
      mul_mcand     <= '0;
      mul_mplier    <= '0;
      mul_b_q       <= '0;
      mul_dest_q    <= '0;
      mul_ctr_m_q   <= '0;
      mul_ctr_wb_q  <= '0;
      reg_alu_out   <= '0;
      reg_reg2_data <= '0;
      reg_write_reg <= '0;
      reg_ctr_m     <= '0;
      reg_ctr_wb    <= '0;
      reg_valid     <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so later statements see the pre-edge values.
      reg_alu_out   <= alu_result;
      reg_reg2_data <= fwd_b;
      reg_write_reg <= dest;
      reg_ctr_m     <= '0;
      reg_ctr_wb    <= '0;
      reg_valid     <= 1'b0;

      if (flush) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid && is_mul) begin
              mul_acc      <= '0;
              mul_mcand    <= op_a;
              mul_mplier   <= op_b;
              mul_b_q      <= fwd_b;
              mul_dest_q   <= dest;
              mul_ctr_m_q  <= ctr_m;
              mul_ctr_wb_q <= ctr_wb;
              count        <= CNT_W'(DATA_W - 1);
              state        <= BUSY;
            end else if (in_valid) begin
              reg_ctr_m  <= ctr_m;
              reg_ctr_wb <= ctr_wb;
              reg_valid  <= 1'b1;
            end
          end
          BUSY: begin
            mul_acc    <= mul_step_acc;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            count      <= count - 1'b1;
            if (count == '0) begin
              reg_alu_out   <= mul_step_acc;
              reg_reg2_data <= mul_b_q;
              reg_write_reg <= mul_dest_q;
              reg_ctr_m     <= mul_ctr_m_q;
              reg_ctr_wb    <= mul_ctr_wb_q;
              reg_valid     <= 1'b1;
              state         <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc: forwarding, ALU ops, multiplier timing,
// reset and flush in the middle of a multiply.
module tb_execute_stage_mc;

  localparam logic [3:0] MUL = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, flush;
  logic [3:0]  ctr_ex;
  logic [2:0]  ctr_m;
  logic [1:0]  ctr_wb;
  logic [31:0] reg1_data, reg2_data, immediate;
  logic [4:0]  rs, rt, rd;
  logic [3:0]  alu_cmd;
  logic [4:0]  ex_write_reg, mem_write_reg;
  logic        ex_regwrite_flag, mem_regwrite_flag;
  logic [31:0] ex_mem_data, mem_wb_data;
  logic        stall_req;
  logic [31:0] reg_alu_out, reg_reg2_data;
  logic [4:0]  reg_write_reg;
  logic [2:0]  reg_ctr_m;
  logic [1:0]  reg_ctr_wb;
  logic        reg_valid;

  int n_checks = 0;
  int n_errors = 0;

  execute_stage_mc #(.DATA_W(32), .RADDR_W(5), .CMD_MUL(MUL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .ctr_ex(ctr_ex), .ctr_m(ctr_m), .ctr_wb(ctr_wb),
    .reg1_data(reg1_data), .reg2_data(reg2_data), .immediate(immediate),
    .rs(rs), .rt(rt), .rd(rd), .alu_cmd(alu_cmd),
    .ex_write_reg(ex_write_reg), .ex_regwrite_flag(ex_regwrite_flag),
    .mem_write_reg(mem_write_reg), .mem_regwrite_flag(mem_regwrite_flag),
    .ex_mem_data(ex_mem_data), .mem_wb_data(mem_wb_data),
    .stall_req(stall_req), .reg_alu_out(reg_alu_out), .reg_reg2_data(reg_reg2_data),
    .reg_write_reg(reg_write_reg), .reg_ctr_m(reg_ctr_m), .reg_ctr_wb(reg_ctr_wb),
    .reg_valid(reg_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic [3:0] cex,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    in_valid = 1'b1; flush = 1'b0;
    alu_cmd = cmd; ctr_ex = cex; ctr_m = 3'b000; ctr_wb = 2'b10;
    reg1_data = a; reg2_data = b; immediate = imm;
    rs = s; rt = t; rd = d;
    ex_regwrite_flag = 1'b0; ex_write_reg = '0; ex_mem_data = '0;
    mem_regwrite_flag = 1'b0; mem_write_reg = '0; mem_wb_data = '0;
  endtask

  // Presents a multiply and counts stall cycles, bubbles and edges until reg_valid.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit disturb,
                         output int stalls, output int bubbles, output int cycles);
    set_op(MUL, 4'b1000, a, b, 32'd0, 5'd1, 5'd2, 5'd9);
    stalls = 0; bubbles = 0; cycles = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (stall_req) stalls++;
      tick();
      cycles++;
      if (disturb && i == 0) begin
        reg1_data = 32'hDEAD_BEEF;
        ex_regwrite_flag = 1'b1; ex_write_reg = 5'd2; ex_mem_data = 32'h1234;
      end
      if (reg_valid) break;
      bubbles++;
    end
  endtask

  int stalls, bubbles, cycles;

  initial begin
    set_op(4'd0, 4'b0000, '0, '0, '0, '0, '0, '0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #2;
    check("reset_alu_out", reg_alu_out, 0);
    check("reset_valid", reg_valid, 0);
    check("reset_ctr_wb", reg_ctr_wb, 0);
    check("reset_write_reg", reg_write_reg, 0);
    check("reset_stall", stall_req, 0);
    tick();
    rst = 1'b0;

    // ADD r3 = 5 + 7
    set_op(4'd2, 4'b1000, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3);
    tick();
    check("add_result", reg_alu_out, 12);
    check("add_dest", reg_write_reg, 3);
    check("add_valid", reg_valid, 1);
    check("add_ctr_wb", reg_ctr_wb, 2'b10);

    // Forwarding priority on operand A, ADD with immediate 1
    set_op(4'd2, 4'b1001, 32'd5, 32'd0, 32'd1, 5'd1, 5'd2, 5'd3);
    ex_regwrite_flag = 1'b1; ex_write_reg = 5'd1; ex_mem_data = 32'd100;
    mem_regwrite_flag = 1'b1; mem_write_reg = 5'd1; mem_wb_data = 32'd50;
    tick();
    check("fwd_ex_wins", reg_alu_out, 101);
    ex_regwrite_flag = 1'b0;
    tick();
    check("fwd_mem", reg_alu_out, 51);
    ex_regwrite_flag = 1'b1; ex_write_reg = 5'd0; mem_write_reg = 5'd0;
    tick();
    check("fwd_r0_ignored", reg_alu_out, 6);

    // Store: address = rs + 8, store data forwarded from MEM/WB
    set_op(4'd2, 4'b0001, 32'd20, 32'd0, 32'd8, 5'd2, 5'd4, 5'd0);
    ctr_m = 3'b001; ctr_wb = 2'b00;
    mem_regwrite_flag = 1'b1; mem_write_reg = 5'd4; mem_wb_data = 32'hAB;
    tick();
    check("sw_addr", reg_alu_out, 28);
    check("sw_store_data", reg_reg2_data, 32'hAB);
    check("sw_dest_rt", reg_write_reg, 4);
    check("sw_ctr_m", reg_ctr_m, 3'b001);

    // Logic and compare operations
    set_op(4'd7, 4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd1, 5'd2, 5'd5);
    tick();
    check("slt_neg_lt_pos", reg_alu_out, 1);
    set_op(4'd7, 4'b1000, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd1, 5'd2, 5'd5);
    tick();
    check("slt_pos_lt_neg", reg_alu_out, 0);
    set_op(4'd6, 4'b1000, 32'd3, 32'd5, 32'd0, 5'd1, 5'd2, 5'd5);
    tick();
    check("sub_wrap", reg_alu_out, 32'hFFFF_FFFE);
    set_op(4'd12, 4'b1000, 32'hF0F0_0000, 32'h0F0F_0000, 32'd0, 5'd1, 5'd2, 5'd5);
    tick();
    check("nor", reg_alu_out, 32'h0000_FFFF);
    set_op(4'd0, 4'b1000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 5'd1, 5'd2, 5'd5);
    tick();
    check("and", reg_alu_out, 32'h0F00_0F00);
    set_op(4'd2, 4'b1000, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd1, 5'd2, 5'd5);
    tick();
    check("add_wrap", reg_alu_out, 32'd1);

    // Bubble on invalid input
    set_op(4'd2, 4'b1000, 32'd1, 32'd1, 32'd0, 5'd1, 5'd2, 5'd5);
    in_valid = 1'b0; ctr_wb = 2'b11; ctr_m = 3'b111;
    tick();
    check("bubble_ctr_wb", reg_ctr_wb, 0);
    check("bubble_ctr_m", reg_ctr_m, 0);
    check("bubble_valid", reg_valid, 0);

    // Multiply, then a second multiply accepted straight away
    run_mul(32'hFFFF_FFFF, 32'd3, 1'b0, stalls, bubbles, cycles);
    check("mul_stall_cycles", stalls, 32);
    check("mul_bubbles", bubbles, 32);
    check("mul_latency", cycles, 33);
    check("mul_product", reg_alu_out, 32'hFFFF_FFFD);
    check("mul_dest", reg_write_reg, 9);
    check("mul_ctr_wb", reg_ctr_wb, 2'b10);
    run_mul(32'd6, 32'd7, 1'b1, stalls, bubbles, cycles);
    check("mul2_latency", cycles, 33);
    check("mul2_stall_cycles", stalls, 32);
    check("mul2_product_latched", reg_alu_out, 42);
    check("mul2_valid", reg_valid, 1);

    // Async reset with count at 10
    set_op(MUL, 4'b1000, 32'd9, 32'd9, 32'd0, 5'd1, 5'd2, 5'd9);
    #1;
    check("mul_accept_stall", stall_req, 1);
    tick();
    repeat (21) tick();
    check("busy_stall_before_rst", stall_req, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_stall", stall_req, 0);
    check("rst_valid", reg_valid, 0);
    check("rst_alu_out", reg_alu_out, 0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    tick();
    set_op(4'd2, 4'b1000, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3);
    #1;
    check("post_rst_add_stall", stall_req, 0);
    tick();
    check("post_rst_add", reg_alu_out, 12);
    check("post_rst_valid", reg_valid, 1);

    // Flush in the middle of a multiply
    set_op(MUL, 4'b1000, 32'd9, 32'd9, 32'd0, 5'd1, 5'd2, 5'd9);
    tick();
    repeat (5) tick();
    flush = 1'b1;
    #1;
    check("flush_stall", stall_req, 0);
    tick();
    check("flush_valid", reg_valid, 0);
    check("flush_ctr_wb", reg_ctr_wb, 0);
    #1;
    check("flush_blocks_mul_accept", stall_req, 0);
    tick();
    set_op(4'd2, 4'b1000, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3);
    #1;
    check("post_flush_idle", stall_req, 0);
    tick();
    check("post_flush_add", reg_alu_out, 12);
    check("post_flush_valid", reg_valid, 1);

    in_valid = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
